// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg: shared types and constants for the multi-sector read sequencer.
//   seq_state_t      : sequencer FSM states
//   SECTOR_BYTES     : bytes delivered by the reader per sector
//   words_per_sector : FIFO words one sector occupies for a given lane count
package sd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_READ,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } seq_state_t;

    localparam int SECTOR_BYTES = 512;

    function automatic int words_per_sector(input int byte_lanes);
        return SECTOR_BYTES / byte_lanes;
    endfunction

endpackage

// File: rtl/sd_seq_fifo.sv
// sd_seq_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   : write request and data; full reports no free slot
//   pop, pop_data     : read request; pop_data shows the head word while !empty
//   free              : number of free slots
//   overflow          : one-cycle flag, push refused because full with no pop
// A push and a pop in the same cycle while full are both honoured.
module sd_seq_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_W);
    assign free     = DEPTH_W - count;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sd_sector_seq.sv
// sd_sector_seq: reads sector_count consecutive sectors from an SD reader
// core starting at first_sector, packs the byte stream into BYTE_LANES-wide
// words and presents them through a FWFT FIFO as a valid/ready stream with
// m_last marking the final word of each sector.
//   start/first_sector/sector_count : job request, sampled in IDLE only
//   busy/done                       : job in progress / one-cycle completion
//   rd_start/rd_sector_no/rd_done   : reader command handshake
//   rd_outreq/rd_outaddr/rd_outbyte : reader byte stream
//   m_valid/m_ready/m_data/m_last   : output stream
//   addr_err/ovf_err                : sticky errors, cleared on a new job
//   err_cnt                         : pattern mismatch count
// Build option: define SD_SEQ_CHECK_EN to compare every accepted byte with
// rd_outaddr[7:0] (FakeSD pattern) and count mismatches in err_cnt; without
// it err_cnt reads 0.
//
// Output handshake: a word transfers on a cycle where m_valid && m_ready;
// m_data/m_last hold steady while m_valid && !m_ready.
module sd_sector_seq
    import sd_seq_pkg::*;
#(
    parameter int BYTE_LANES = 4,
    parameter int FIFO_DEPTH = 256,
    parameter int SECCNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [31:0]             first_sector,
    input  logic [SECCNT_W-1:0]     sector_count,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_start,
    output logic [31:0]             rd_sector_no,
    input  logic                    rd_done,
    input  logic                    rd_outreq,
    input  logic [8:0]              rd_outaddr,
    input  logic [7:0]              rd_outbyte,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*BYTE_LANES-1:0] m_data,
    output logic                    m_last,
    output logic                    addr_err,
    output logic                    ovf_err,
    output logic [15:0]             err_cnt
);

    localparam int W      = 8 * BYTE_LANES;
    localparam int WPS    = words_per_sector(BYTE_LANES);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [31:0]           sector_no;
    logic [SECCNT_W-1:0]   remaining;
    logic                  busy_q;
    logic                  done_q;
    logic                  addr_err_q;
    logic                  ovf_err_q;

    // Bit 9 flags that a full sector has been received; further strobes
    // are not placed into words.
    logic [9:0]            byte_cnt;
    logic [8:0]            cnt9;
    logic [8:0]            lane_idx;
    logic [W-1:0]          word_q;
    logic [W-1:0]          push_word;

    logic                  in_read;
    logic                  strobe;
    logic                  accept;
    logic                  push;
    logic                  short_sector;
    logic                  start_job;
    logic                  space_ok;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_ovf;
    logic [FREE_W-1:0]     fifo_free;
    logic [W:0]            fifo_head;

    assign in_read   = (state == ST_READ);
    assign strobe    = in_read && rd_outreq;
    assign accept    = strobe && !byte_cnt[9];
    assign cnt9      = byte_cnt[8:0];
    assign lane_idx  = cnt9 & 9'(BYTE_LANES - 1);
    assign push      = accept && (lane_idx == 9'(BYTE_LANES - 1));
    assign start_job = (state == ST_IDLE) && start && (sector_count != '0);
    assign space_ok  = (fifo_free >= FREE_W'(WPS));

    // rd_done before the 512th strobe (counting one arriving this cycle).
    assign short_sector = in_read && rd_done &&
                          ((byte_cnt + {9'd0, accept}) != 10'd512);

    always_comb begin
        push_word = word_q;
        push_word[W-8 +: 8] = rd_outbyte;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (sector_count == '0) ? ST_DONE : ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (space_ok) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_done) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                // When room for the next sector already exists, re-issue
                // straight away so rd_start drops for a single cycle.
                if (remaining > SECCNT_W'(1)) begin
                    state_nxt = space_ok ? ST_READ : ST_WAIT_SPACE;
                end else begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sector_no  <= '0;
            remaining  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            byte_cnt   <= '0;
            word_q     <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ST_DONE);

            if ((state == ST_IDLE) && start) begin
                busy_q <= 1'b1;
            end else if (state == ST_DONE) begin
                busy_q <= 1'b0;
            end

            if (start_job) begin
                sector_no  <= first_sector;
                remaining  <= sector_count;
                addr_err_q <= 1'b0;
                ovf_err_q  <= 1'b0;
            end else begin
                if (state == ST_GAP) begin
                    sector_no <= sector_no + 32'd1;
                    remaining <= remaining - SECCNT_W'(1);
                end
                if ((accept && (rd_outaddr != cnt9)) ||
                    (strobe && byte_cnt[9]) || short_sector) begin
                    addr_err_q <= 1'b1;
                end
                if (fifo_ovf) begin
                    ovf_err_q <= 1'b1;
                end
            end

            if (!in_read) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 10'd1;
            end

            if (accept) begin
                for (int k = 0; k < BYTE_LANES; k++) begin
                    if (lane_idx == 9'(k)) begin
                        word_q[8*k +: 8] <= rd_outbyte;
                    end
                end
            end
        end
    end

`ifdef SD_SEQ_CHECK_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (start_job) begin
            err_cnt_q <= '0;
        end else if (accept && (rd_outbyte != rd_outaddr[7:0]) &&
                     (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

    sd_seq_fifo #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({(cnt9 == 9'd511), push_word}),
        .full      (fifo_full),
        .pop       (m_valid && m_ready),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .free      (fifo_free),
        .overflow  (fifo_ovf)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_start     = in_read;
    assign rd_sector_no = sector_no;
    assign addr_err     = addr_err_q;
    assign ovf_err      = ovf_err_q;
    assign m_valid      = !fifo_empty;
    assign m_data       = fifo_empty ? '0 : fifo_head[W-1:0];
    assign m_last       = !fifo_empty && fifo_head[W];

endmodule
